fen_board_loader: RTL and testbench
===================================

# fen_board_loader

Consumes the per-square piece stream and side-state fields produced by the FEN decoder and assembles them into a complete, registered 64-square board image plus game-state fields. It sits directly downstream of the FEN decoder and presents the board to the move-generator front end with a valid/ack handshake. It also performs basic sanity checks: square count, king count and stream overrun.

## Interface
Parameters:
- GAP_TIMEOUT, 16: max idle cycles between consecutive squares inside a load before it is aborted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one square per cycle when high.
- in_pdata  in  4  square code: [3] = white, [2:0] = 0 empty, 1..6 = P R N B Q K.
- in_turn  in  1  side to move, 1 = white; stable while in_valid is high.
- in_castle  in  4  castling rights KQkq; stable while in_valid is high.
- in_ep  in  3  en-passant file; stable while in_valid is high.
- in_hmcount  in  16  halfmove clock; stable while in_valid is high.
- in_fmcount  in  16  fullmove number; stable while in_valid is high.
- board_ack  in  1  consumer has taken the board.
- board_valid  out  1  board image and fields are complete and stable.
- board  out  256  square s at bits [4s+3:4s], a1 = 0, h8 = 63.
- o_turn, o_castle, o_ep, o_hmcount, o_fmcount  out  1/4/3/16/16  latched side state.
- err_kings  out  1  valid with board_valid; white or black king count is not exactly 1.
- err_short  out  1  one-cycle pulse; load aborted by gap timeout.
- err_overrun  out  1  one-cycle pulse per in_valid beat dropped while in HOLD.

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE:
  - in_valid starts a load. That beat is square index 0.
  - On that beat, in_turn, in_castle, in_ep, in_hmcount and in_fmcount are latched; the king counters and gap counter are cleared.
  - Go to LOAD with idx = 1.
- LOAD:
  - Each in_valid beat writes in_pdata to sq = (7 − idx[5:3])·8 + idx[2:0]. The stream is FEN order: a8..h8, a7..h7, … a1..h1.
  - Write to the board register and increment idx.
  - On the beat with idx = 63: go to HOLD.
  - No in_valid for GAP_TIMEOUT consecutive cycles: pulse err_short and return to IDLE. The partial board is left in place; board_valid stays 0.
- HOLD:
  - board_valid = 1.
  - On board_ack: go to IDLE.
  - in_valid in HOLD is dropped and pulses err_overrun. This applies even on the cycle board_ack is high; that beat is not the start of a new load.
- King check:
  - Two 2-bit saturating counters, one for codes 4'b1110 (white K) and one for 4'b0110 (black K).
  - err_kings = (wk ≠ 1) | (bk ≠ 1), gated by board_valid.
- Board register: written only in IDLE→LOAD and LOAD beats; board is held in all other states.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - board, board_valid, err_* and all o_* fields = 0.
- board_valid rises the cycle after the 64th in_valid beat; latency is 1 cycle from the last square.
- board_valid falls the cycle after board_ack is sampled high in HOLD. The earliest next load beat is accepted the cycle after that.
- err_short asserts on the cycle the gap counter reaches GAP_TIMEOUT: the GAP_TIMEOUT-th consecutive idle cycle in LOAD.
- Board contents are updated incrementally during LOAD. The consumer must use them only while board_valid = 1.
- Asynchronous reset mid-load or in HOLD returns immediately to reset values. No partial board is reported.

## Structure
- Shared package chess_pkg holds:
  - the piece-code localparams (EMPTY, PAWN..KING, the WHITE bit), reused by the move generator;
  - function fen_idx_to_sq(idx) returning the 6-bit square.
- One sub-module, sat_count2: 2-bit saturating counter with clear and increment enable, instantiated twice for the king counts.
- Everything else lives in this module: FSM, idx and gap counters, 64×4 board flops.

## Test plan
- Start position stream (r n b q k b n r, p×8, 32 empty, P×8, R N B Q K B N R), turn 1, castle 4'b1111, hm 0, fm 1:
  - board_valid 1 cycle after beat 64;
  - sq 0 = 4'b1010 (white R), sq 4 = 4'b1110, sq 60 = 4'b0110;
  - o_fmcount = 1, err_kings = 0.
- Same stream with the black king replaced by empty → err_kings = 1. Stream with three white kings → counter saturates at 3, err_kings = 1.
- Stream of 40 beats, then idle:
  - err_short pulses exactly GAP_TIMEOUT (16) cycles after beat 40;
  - FSM returns to IDLE; board_valid is never asserted.
- Complete load held without ack; 5 more in_valid beats → 5 err_overrun pulses, board unchanged.
- In HOLD, assert board_ack and in_valid in the same cycle:
  - that beat is dropped with an overrun pulse;
  - board_valid falls the next cycle;
  - a new 64-beat stream then loads normally.
- Drive rst_n low asynchronously at beat 30 of a load → all outputs 0 immediately. A subsequent full stream loads correctly from idx 0.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, FEN index mapping and loader state type shared by the chess front end.
package chess_pkg;
  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] ROOK   = 3'd2;
  localparam logic [2:0] KNIGHT = 3'd3;
  localparam logic [2:0] BISHOP = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;
  localparam int WHITE_BIT = 3;
  localparam logic [3:0] W_KING = {1'b1, KING};
  localparam logic [3:0] B_KING = {1'b0, KING};
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} fbl_state_t;
  // FEN streams rank 8 first, so the rank field is mirrored
  function automatic logic [5:0] fen_idx_to_sq(input logic [5:0] idx);
    return {3'd7 - idx[5:3], idx[2:0]};
  endfunction
endpackage

// File: rtl/sat_count2.sv
// sat_count2: 2-bit saturating counter; clear wins but still counts the clearing beat.
module sat_count2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [1:0] o_cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_cnt <= 2'd0;
    else if (i_clr) o_cnt <= {1'b0, i_inc};
    else if (i_inc && o_cnt != 2'd3) o_cnt <= o_cnt + 2'd1;
endmodule

// File: rtl/fen_board_loader.sv
// fen_board_loader: assembles the FEN decoder square stream into a held 64-square board image
// with side state, king-count, gap-timeout and overrun checks.
module fen_board_loader import chess_pkg::*; #(
  parameter int GAP_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   in_pdata,
  input  logic         in_turn,
  input  logic [3:0]   in_castle,
  input  logic [2:0]   in_ep,
  input  logic [15:0]  in_hmcount,
  input  logic [15:0]  in_fmcount,
  input  logic         board_ack,
  output logic         board_valid,
  output logic [255:0] board,
  output logic         o_turn,
  output logic [3:0]   o_castle,
  output logic [2:0]   o_ep,
  output logic [15:0]  o_hmcount,
  output logic [15:0]  o_fmcount,
  output logic         err_kings,
  output logic         err_short,
  output logic         err_overrun
);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  fbl_state_t      r_state;
  logic [5:0]      r_idx;
  logic [GW-1:0]   r_gap;
  logic [1:0]      w_wk, w_bk;
  logic            w_start, w_wr;
  logic [5:0]      w_sq;
  assign w_start = r_state == S_IDLE && in_valid;
  assign w_wr    = w_start || (r_state == S_LOAD && in_valid);
  assign w_sq    = fen_idx_to_sq(r_idx);
  assign err_kings = board_valid && (w_wk != 2'd1 || w_bk != 2'd1);
  sat_count2 u_wk (.clk(clk), .rst_n(rst_n), .i_clr(w_start), .i_inc(w_wr && in_pdata == W_KING), .o_cnt(w_wk));
  sat_count2 u_bk (.clk(clk), .rst_n(rst_n), .i_clr(w_start), .i_inc(w_wr && in_pdata == B_KING), .o_cnt(w_bk));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 6'd0;
      r_gap       <= '0;
      board       <= '0;
      board_valid <= 1'b0;
      o_turn      <= 1'b0;
      o_castle    <= 4'd0;
      o_ep        <= 3'd0;
      o_hmcount   <= 16'd0;
      o_fmcount   <= 16'd0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_short   <= 1'b0;
      err_overrun <= r_state == S_HOLD && in_valid;
      if (w_wr) board[{w_sq, 2'b00} +: 4] <= in_pdata;
      case (r_state)
        S_IDLE: if (in_valid) begin
          o_turn    <= in_turn;
          o_castle  <= in_castle;
          o_ep      <= in_ep;
          o_hmcount <= in_hmcount;
          o_fmcount <= in_fmcount;
          r_gap     <= '0;
          r_idx     <= 6'd1;
          r_state   <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          r_gap <= '0;
          r_idx <= r_idx + 6'd1;
          if (r_idx == 6'd63) begin
            r_state     <= S_HOLD;
            board_valid <= 1'b1;
          end
        end else if (r_gap == GW'(GAP_TIMEOUT - 1)) begin
          err_short <= 1'b1;
          r_idx     <= 6'd0;
          r_state   <= S_IDLE;
        end else r_gap <= r_gap + 1'b1;
        S_HOLD: if (board_ack) begin
          board_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fen_board_loader.sv
// tb_fen_board_loader: scoreboard bench; stimulus pushes expected boards/pulses, a negedge monitor pops and checks.
module tb_fen_board_loader;
  logic clk = 0, rst_n = 0, in_valid = 0, in_turn = 0, board_ack = 0;
  logic [3:0] in_pdata = 0, in_castle = 0;
  logic [2:0] in_ep = 0;
  logic [15:0] in_hmcount = 0, in_fmcount = 0;
  logic board_valid, o_turn, err_kings, err_short, err_overrun;
  logic [255:0] board;
  logic [3:0] o_castle;
  logic [2:0] o_ep;
  logic [15:0] o_hmcount, o_fmcount;
  fen_board_loader #(.GAP_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pdata(in_pdata), .in_turn(in_turn),
    .in_castle(in_castle), .in_ep(in_ep), .in_hmcount(in_hmcount), .in_fmcount(in_fmcount),
    .board_ack(board_ack), .board_valid(board_valid), .board(board), .o_turn(o_turn),
    .o_castle(o_castle), .o_ep(o_ep), .o_hmcount(o_hmcount), .o_fmcount(o_fmcount),
    .err_kings(err_kings), .err_short(err_short), .err_overrun(err_overrun));
  always #5 clk = ~clk;
  typedef struct {
    logic [255:0] b;
    logic t;
    logic [3:0] c;
    logic [2:0] e;
    logic [15:0] h, f;
    logic k;
    int cy;
  } exp_t;
  exp_t q_board[$];
  int q_short[$], q_over[$];
  exp_t cur;
  int cyc = 0, tests = 0, fails = 0;
  logic prev_bv = 0;
  logic [3:0] st [64];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask
  function automatic exp_t model(input int cy);
    exp_t x;
    int wk = 0, bk = 0;
    x.b = '0;
    for (int i = 0; i < 64; i++) begin
      x.b[4 * ((7 - i / 8) * 8 + i % 8) +: 4] = st[i];
      if (st[i] == 4'b1110 && wk < 3) wk++;
      if (st[i] == 4'b0110 && bk < 3) bk++;
    end
    x.t = in_turn; x.c = in_castle; x.e = in_ep; x.h = in_hmcount; x.f = in_fmcount;
    x.k = (wk != 1) || (bk != 1);
    x.cy = cy;
    return x;
  endfunction
  task automatic set_start();
    logic [3:0] r8 [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h4, 4'h3, 4'h2};
    for (int i = 0; i < 64; i++) st[i] = 4'h0;
    for (int i = 0; i < 8; i++) begin
      st[i] = r8[i];
      st[8 + i] = 4'h1;
      st[48 + i] = 4'h9;
      st[56 + i] = r8[i] | 4'h8;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      in_pdata = st[i];
      in_valid = 1;
      if (i == 63) q_board.push_back(model(cyc + 1));
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask
  task automatic ack();
    board_ack = 1;
    @(posedge clk); #1;
    board_ack = 0;
    chk("ack_fall", board_valid, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_board"}, board, 0);
    chk({nm, "_fields"}, {board_valid, o_turn, o_castle, o_ep, o_hmcount, o_fmcount, err_kings, err_short, err_overrun}, 0);
  endtask
  always @(negedge clk) begin
    if (board_valid && !prev_bv) begin
      if (q_board.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        cur = q_board.pop_front();
        chk("valid_cycle", cyc, cur.cy);
        chk("turn", o_turn, cur.t);
        chk("castle", o_castle, cur.c);
        chk("ep", o_ep, cur.e);
        chk("hmcount", o_hmcount, cur.h);
        chk("fmcount", o_fmcount, cur.f);
        chk("err_kings", err_kings, cur.k);
      end
    end
    if (board_valid) chk("board", board, cur.b);
    else if (err_kings) chk("kings_gated", err_kings, 0);
    if (err_short) begin
      if (q_short.size() == 0) chk("unexpected_short", 1, 0);
      else chk("short_cycle", cyc, q_short.pop_front());
    end
    if (err_overrun) begin
      if (q_over.size() == 0) chk("unexpected_overrun", 1, 0);
      else chk("overrun_cycle", cyc, q_over.pop_front());
    end
    prev_bv = board_valid;
  end
  initial begin
    #1 chk_zero("reset");
    #11 rst_n = 1;
    @(posedge clk); #1;
    set_start();
    in_turn = 1; in_castle = 4'hF; in_ep = 0; in_hmcount = 0; in_fmcount = 1;
    run(64);
    chk("start_valid", board_valid, 1);
    chk("sq0_wrook", board[3:0], 4'b1010);
    chk("sq4_wking", board[19:16], 4'b1110);
    chk("sq60_bking", board[243:240], 4'b0110);
    chk("start_fm", o_fmcount, 16'd1);
    chk("start_kings", err_kings, 0);
    repeat (2) @(posedge clk); #1;
    ack();
    st[4] = 4'h0;
    run(64);
    chk("no_bking", err_kings, 1);
    ack();
    set_start();
    st[57] = 4'hE; st[62] = 4'hE;
    in_turn = 0; in_castle = 4'b0101; in_ep = 3'd5; in_hmcount = 16'd37; in_fmcount = 16'd120;
    run(64);
    chk("three_wkings", err_kings, 1);
    ack();
    set_start();
    in_turn = 1; in_castle = 4'b1001; in_ep = 3'd2; in_hmcount = 16'd3; in_fmcount = 16'd9;
    run(40);
    q_short.push_back(cyc + 16);
    repeat (20) @(posedge clk); #1;
    chk("short_no_valid", board_valid, 0);
    run(64);
    ack();
    run(64);
    for (int i = 0; i < 5; i++) begin
      in_pdata = 4'(i + 3);
      in_valid = 1;
      q_over.push_back(cyc + 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (2) @(posedge clk); #1;
    chk("overrun_held", board_valid, 1);
    ack();
    run(64);
    board_ack = 1; in_valid = 1; in_pdata = 4'hE;
    q_over.push_back(cyc + 1);
    @(posedge clk); #1;
    board_ack = 0; in_valid = 0;
    chk("ack_overrun_fall", board_valid, 0);
    st[10] = 4'hD; st[33] = 4'h3;
    in_fmcount = 16'd77;
    run(64);
    chk("reload_valid", board_valid, 1);
    ack();
    set_start();
    run(30);
    #2 rst_n = 0;
    #1 chk_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1;
    in_turn = 0; in_castle = 4'b0010; in_ep = 3'd7; in_hmcount = 16'd5; in_fmcount = 16'd44;
    run(64);
    chk("post_reset_sq56", board[227:224], 4'h2);
    ack();
    repeat (3) @(posedge clk); #1;
    chk("q_board_drained", q_board.size(), 0);
    chk("q_short_drained", q_short.size(), 0);
    chk("q_over_drained", q_over.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
